cla_seq_ctrl: RTL and testbench



---
 rtl/cla_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cla_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_ctrl.sv
// ============================================================================
//  Module   : cla_seq_ctrl
//  Purpose  : Byte-serial wide add/subtract sequencer driving one external
//             combinational 8-bit adder slice, LSB byte first, carry chained
//             in a register. Optional macro CLA_SEQ_ZERO_FLAG_EN adds `zero`.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [8*WORDS-1:0]   op_a,
    input  logic [8*WORDS-1:0]   op_b,
    input  logic                 sub,
    output logic [7:0]           adder_a,
    output logic [7:0]           adder_b,
    output logic                 adder_cin,
    input  logic [7:0]           adder_sum,
    input  logic                 adder_cout,
    output logic [8*WORDS-1:0]   result,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 done_valid,
    input  logic                 done_ready
`ifdef CLA_SEQ_ZERO_FLAG_EN
    ,
    output logic                 zero
`endif
);

    localparam int              W      = 8 * WORDS;
    localparam int              IW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0]   C_LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_result;
    logic            r_cout;
    logic            r_ovf;
    logic            r_start_ready;
    logic            r_done_valid;
`ifdef CLA_SEQ_ZERO_FLAG_EN
    logic            r_nz;
    logic            r_zero;
`endif

    logic [7:0]      w_a_bytes [WORDS];
    logic [7:0]      w_b_bytes [WORDS];
    logic            w_run;

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_bytes
            assign w_a_bytes[gi] = r_a[8*gi +: 8];
            assign w_b_bytes[gi] = r_b[8*gi +: 8];
        end
    endgenerate

    assign w_run = (r_state == S_RUN);

    // Adder inputs are forced to zero outside RUN so the slice sees no toggling.
    assign adder_a   = w_run ? w_a_bytes[r_idx] : 8'h00;
    assign adder_b   = w_run ? w_b_bytes[r_idx] : 8'h00;
    assign adder_cin = w_run ? r_carry : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_carry       <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_result      <= '0;
            r_cout        <= 1'b0;
            r_ovf         <= 1'b0;
            r_start_ready <= 1'b1;
            r_done_valid  <= 1'b0;
`ifdef CLA_SEQ_ZERO_FLAG_EN
            r_nz          <= 1'b0;
            r_zero        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_a           <= op_a;
                        r_b           <= sub ? ~op_b : op_b;
                        r_carry       <= sub;
                        r_idx         <= '0;
                        r_start_ready <= 1'b0;
                        r_state       <= S_RUN;
`ifdef CLA_SEQ_ZERO_FLAG_EN
                        r_nz          <= 1'b0;
`endif
                    end
                end

                S_RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (r_idx == IW'(i)) begin
                            r_result[8*i +: 8] <= adder_sum;
                        end
                    end
                    r_carry <= adder_cout;
                    r_idx   <= r_idx + IW'(1);
`ifdef CLA_SEQ_ZERO_FLAG_EN
                    r_nz    <= r_nz | (|adder_sum);
`endif
                    if (r_idx == C_LAST) begin
                        // Operand signs come from the latched (possibly inverted) B.
                        r_cout       <= adder_cout;
                        r_ovf        <= (r_a[W-1] == r_b[W-1]) &&
                                        (adder_sum[7] != r_a[W-1]);
                        r_done_valid <= 1'b1;
                        r_state      <= S_DONE;
`ifdef CLA_SEQ_ZERO_FLAG_EN
                        r_zero       <= ~(r_nz | (|adder_sum));
`endif
                    end
                end

                S_DONE: begin
                    if (done_ready) begin
                        r_done_valid  <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end

                default: begin
                    r_done_valid  <= 1'b0;
                    r_start_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign start_ready = r_start_ready;
    assign done_valid  = r_done_valid;
    assign result      = r_result;
    assign carry_out   = r_cout;
    assign overflow    = r_ovf;
`ifdef CLA_SEQ_ZERO_FLAG_EN
    assign zero        = r_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cla_seq_ctrl.sv
// ============================================================================
//  Module   : tb_cla_seq_ctrl
//  Purpose  : Self-checking bench for cla_seq_ctrl with an arithmetic model
//             and a behavioural 8-bit adder slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_seq_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic           clk;
    logic           rst_n;
    logic           start_valid;
    logic           start_ready;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           sub;
    logic [7:0]     adder_a;
    logic [7:0]     adder_b;
    logic           adder_cin;
    logic [7:0]     adder_sum;
    logic           adder_cout;
    logic [W-1:0]   result;
    logic           carry_out;
    logic           overflow;
    logic           done_valid;
    logic           done_ready;
`ifdef CLA_SEQ_ZERO_FLAG_EN
    logic           zero;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cla_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .sub         (sub),
        .adder_a     (adder_a),
        .adder_b     (adder_b),
        .adder_cin   (adder_cin),
        .adder_sum   (adder_sum),
        .adder_cout  (adder_cout),
        .result      (result),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
`ifdef CLA_SEQ_ZERO_FLAG_EN
        ,
        .zero        (zero)
`endif
    );

    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {8'h00, adder_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a job is "edges since accept"; the answer is plain W+1-bit arithmetic.
    logic           m_busy;
    int             m_k;
    logic [W-1:0]   m_A, m_Bp, m_res;
    logic           m_sub, m_cout, m_ovf, m_zero;

    function automatic logic cin_at(int k);
        logic [W:0] mask;
        logic [W:0] s;
        mask = ((W+1)'(1) << (8*k)) - (W+1)'(1);
        s = ({1'b0, m_A} & mask) + ({1'b0, m_Bp} & mask) + (W+1)'(m_sub);
        return s[8*k];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_k = 0; m_res = '0;
            m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
            m_A = '0; m_Bp = '0; m_sub = 1'b0;
        end else if (!m_busy) begin
            if (start_valid) begin
                m_busy = 1'b1; m_k = 0;
                m_A = op_a; m_Bp = sub ? ~op_b : op_b; m_sub = sub;
            end
        end else if (m_k < WORDS) begin
            m_k++;
            if (m_k == WORDS) begin
                {m_cout, m_res} = {1'b0, m_A} + {1'b0, m_Bp} + (W+1)'(m_sub);
                m_ovf  = (m_A[W-1] == m_Bp[W-1]) && (m_res[W-1] != m_A[W-1]);
                m_zero = (m_res == '0);
            end
        end else if (done_ready) begin
            m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("start_ready", W'(start_ready), W'(!m_busy));
            chk("done_valid", W'(done_valid), W'(m_busy && m_k >= WORDS));
            if (m_busy && m_k < WORDS) begin
                chk("adder_a", W'(adder_a), W'(m_A[8*m_k +: 8]));
                chk("adder_b", W'(adder_b), W'(m_Bp[8*m_k +: 8]));
                chk("adder_cin", W'(adder_cin), W'(cin_at(m_k)));
            end else begin
                chk("adder_idle", {adder_a, adder_b, adder_cin}, '0);
                chk("result", result, m_res);
                chk("carry_out", W'(carry_out), W'(m_cout));
                chk("overflow", W'(overflow), W'(m_ovf));
`ifdef CLA_SEQ_ZERO_FLAG_EN
                chk("zero", W'(zero), W'(m_zero));
`endif
            end
        end
    end

    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input logic exp_cin1, input logic [W-1:0] exp_res,
                           input logic exp_c, input logic exp_o, input logic exp_z,
                           input int hold);
        bit seen;
        @(posedge clk) #1;
        op_a = a; op_b = b; sub = s; start_valid = 1'b1;
        @(posedge clk) #1;
        start_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; sub = ~s;
        @(posedge clk) #1;
        chk("lit_cin_slice1", W'(adder_cin), W'(exp_cin1));
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done_valid) seen = 1'b1;
            else @(posedge clk) #1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: done_valid 0 expected 1 at %0t", $time);
        end
        chk("lit_result", result, exp_res);
        chk("lit_carry", W'(carry_out), W'(exp_c));
        chk("lit_ovf", W'(overflow), W'(exp_o));
`ifdef CLA_SEQ_ZERO_FLAG_EN
        chk("lit_zero", W'(zero), W'(exp_z));
`else
        if (exp_z) op_b = '0;
`endif
        for (int h = 0; h < hold; h++) begin
            start_valid = (h % 2 == 0);
            @(posedge clk) #1;
            chk("lit_hold_result", result, exp_res);
            chk("lit_hold_ready", W'(start_ready), '0);
        end
        start_valid = 1'b0;
        done_ready = 1'b1;
        @(posedge clk) #1;
        done_ready = 1'b0;
        chk("lit_back_idle", W'(start_ready), W'(1));
    endtask

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; done_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #2;
        chk("lit_rst_result", result, '0);
        chk("lit_rst_flags", W'({carry_out, overflow, done_valid}), '0);
        chk("lit_rst_ready", W'(start_ready), W'(1));
        chk("lit_rst_adder", W'({adder_a, adder_b, adder_cin}), '0);

        run_job(32'h000000FF, 32'h00000001, 1'b0, 1'b1, 32'h00000100, 1'b0, 1'b0, 1'b0, 0);
        run_job(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 3);
        run_job(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 0);
        run_job(32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0);
        run_job(32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1);

        // Abort a job while slice 2 is on the adder.
        @(posedge clk) #1;
        op_a = 32'h12345678; op_b = 32'h11111111; sub = 1'b0; start_valid = 1'b1;
        @(posedge clk) #1;
        start_valid = 1'b0;
        @(posedge clk) #1;
        @(posedge clk) #1;
        rst_n = 1'b0;
        #1;
        chk("lit_abort_ready", W'(start_ready), W'(1));
        chk("lit_abort_done", W'(done_valid), '0);
        chk("lit_abort_result", result, '0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("lit_abort_no_done", W'(done_valid), '0);

        run_job(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
